// File: rtl/usb_xfer_sequencer.sv
// USB-domain sequencer: moves address/instruction words to the FPGA
// domain over a 4-phase req/ack handshake and clears the status flags.
module usb_xfer_sequencer #(
    parameter int DATA_W         = 32,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic              usb_clk,
    input  logic              rst_n,
    input  logic              addr_valid_i,
    input  logic              instr_valid_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic              fpga_ack_async_i,
    input  logic              timeout_clr_i,
    output logic              fpga_req_o,
    output logic              fpga_sel_o,
    output logic [DATA_W-1:0] fpga_data_o,
    output logic              rst_new_addr_valid_o,
    output logic              rst_instr_valid_o,
    output logic              busy_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  xfer_count_o
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_CLR  = 3'd2,
        S_DROP = 3'd3,
        S_ERR  = 3'd4
    } state_e;

    state_e               state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [WAIT_W-1:0]    wait_q;
    logic                 req_q;
    logic                 sel_q;
    logic [DATA_W-1:0]    data_q;
    logic                 clr_addr_q;
    logic                 clr_instr_q;
    logic                 busy_q;
    logic                 timeout_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ack_s;

    assign ack_s = sync_q[SYNC_STAGES-1];

    // Bring the FPGA-domain ack into usb_clk through a flop chain
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], fpga_ack_async_i};
        end
    end

    // Handshake FSM with registered outputs, wait counter and statistics
    always_ff @(posedge usb_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            req_q       <= 1'b0;
            sel_q       <= 1'b0;
            data_q      <= '0;
            clr_addr_q  <= 1'b1;
            clr_instr_q <= 1'b1;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            clr_addr_q  <= 1'b1;
            clr_instr_q <= 1'b1;
            if (timeout_clr_i) begin
                timeout_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (addr_valid_i) begin
                        data_q  <= addr_i;
                        sel_q   <= 1'b0;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        wait_q  <= '0;
                        state_q <= S_REQ;
                    end else if (instr_valid_i) begin
                        data_q  <= instr_i;
                        sel_q   <= 1'b1;
                        req_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        wait_q  <= '0;
                        state_q <= S_REQ;
                    end else begin
                        req_q  <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (ack_s) begin
                        clr_addr_q  <= sel_q;
                        clr_instr_q <= ~sel_q;
                        cnt_q       <= cnt_q + CNT_W'(1);
                        state_q     <= S_CLR;
                    end else if (wait_q >= WAIT_LAST) begin
                        req_q     <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= S_ERR;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_CLR: begin
                    req_q   <= 1'b0;
                    wait_q  <= '0;
                    state_q <= S_DROP;
                end
                S_DROP: begin
                    if (!ack_s) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (wait_q >= WAIT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= S_ERR;
                    end else begin
                        wait_q <= wait_q + WAIT_W'(1);
                    end
                end
                S_ERR: begin
                    req_q <= 1'b0;
                    if (!ack_s) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fpga_req_o           = req_q;
    assign fpga_sel_o           = sel_q;
    assign fpga_data_o          = data_q;
    assign rst_new_addr_valid_o = clr_addr_q;
    assign rst_instr_valid_o    = clr_instr_q;
    assign busy_o               = busy_q;
    assign timeout_o            = timeout_q;
    assign xfer_count_o         = cnt_q;

endmodule

// File: tb/tb_usb_xfer_sequencer.sv
// Directed bench for usb_xfer_sequencer: handshake, arbitration,
// timeout/retry, reset mid-transfer, counter wrap and ack held in DROP.
module tb_usb_xfer_sequencer;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          addr_valid = 1'b0;
    logic          instr_valid = 1'b0;
    logic [DW-1:0] addr_d = '0;
    logic [DW-1:0] instr_d = '0;
    logic          ack = 1'b0;
    logic          tclr = 1'b0;
    logic          req_o, sel_o, rst_addr_o, rst_instr_o, busy_o, timeout_o;
    logic [DW-1:0] data_o;
    logic [CW-1:0] cnt_o;

    int checks = 0;
    int failures = 0;
    int addr_pulses = 0;
    int instr_pulses = 0;
    int both_low = 0;
    bit model_en = 1'b1;

    usb_xfer_sequencer #(
        .DATA_W(DW), .SYNC_STAGES(2), .TIMEOUT_CYCLES(16), .CNT_W(CW)
    ) dut (
        .usb_clk(clk), .rst_n(rst_n),
        .addr_valid_i(addr_valid), .instr_valid_i(instr_valid),
        .addr_i(addr_d), .instr_i(instr_d),
        .fpga_ack_async_i(ack), .timeout_clr_i(tclr),
        .fpga_req_o(req_o), .fpga_sel_o(sel_o), .fpga_data_o(data_o),
        .rst_new_addr_valid_o(rst_addr_o), .rst_instr_valid_o(rst_instr_o),
        .busy_o(busy_o), .timeout_o(timeout_o), .xfer_count_o(cnt_o)
    );

    always #5 clk = ~clk;

    // Status-register model: a low clear pulse drops the matching flag
    always @(negedge clk) begin
        if (!rst_addr_o) begin
            addr_pulses++;
            if (model_en) addr_valid = 1'b0;
        end
        if (!rst_instr_o) begin
            instr_pulses++;
            if (model_en) instr_valid = 1'b0;
        end
        if (!rst_addr_o && !rst_instr_o) both_low++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic xfer(input logic exp_sel, input logic [DW-1:0] exp_data,
                        input int exp_lat, input string nm);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_o && n < 10);
        checks++;
        if (req_o !== 1'b1) begin
            failures++; $display("FAIL %s_req got=%b want=1", nm, req_o);
        end
        if (exp_lat > 0) begin
            checks++;
            if (n !== exp_lat) begin
                failures++; $display("FAIL %s_latency got=%0d want=%0d", nm, n, exp_lat);
            end
        end
        checks++;
        if (sel_o !== exp_sel) begin
            failures++; $display("FAIL %s_sel got=%b want=%b", nm, sel_o, exp_sel);
        end
        checks++;
        if (data_o !== exp_data) begin
            failures++; $display("FAIL %s_data got=%h want=%h", nm, data_o, exp_data);
        end
        repeat (3) @(negedge clk);
        ack = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (req_o && n < 30);
        checks++;
        if (req_o !== 1'b0) begin
            failures++; $display("FAIL %s_req_drop got=%b want=0", nm, req_o);
        end
        repeat (3) @(negedge clk);
        ack = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (busy_o && n < 30);
        checks++;
        if (busy_o !== 1'b0) begin
            failures++; $display("FAIL %s_idle got=%b want=0", nm, busy_o);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({req_o, sel_o, busy_o, timeout_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000", {req_o, sel_o, busy_o, timeout_o});
        end
        checks++;
        if (data_o !== '0 || cnt_o !== '0) begin
            failures++; $display("FAIL reset_data got=%h/%0d want=0/0", data_o, cnt_o);
        end
        checks++;
        if ({rst_addr_o, rst_instr_o} !== 2'b11) begin
            failures++;
            $display("FAIL reset_clr got=%b want=11", {rst_addr_o, rst_instr_o});
        end
    endtask

    task automatic test_single_addr();
        int ap, ip;
        ap = addr_pulses; ip = instr_pulses;
        addr_d = 32'h0000_1000;
        addr_valid = 1'b1;
        xfer(1'b0, 32'h0000_1000, 1, "t1");
        checks++;
        if (cnt_o !== 4'd1) begin
            failures++; $display("FAIL t1_count got=%0d want=1", cnt_o);
        end
        checks++;
        if (addr_pulses - ap !== 1 || instr_pulses - ip !== 0) begin
            failures++;
            $display("FAIL t1_pulses got=%0d/%0d want=1/0", addr_pulses - ap, instr_pulses - ip);
        end
    endtask

    task automatic test_arbitration();
        int ap, ip;
        ap = addr_pulses; ip = instr_pulses;
        addr_d = 32'h0000_2000;
        instr_d = 32'hDEAD_BEEF;
        addr_valid = 1'b1;
        instr_valid = 1'b1;
        xfer(1'b0, 32'h0000_2000, 0, "t2_addr");
        xfer(1'b1, 32'hDEAD_BEEF, 0, "t2_instr");
        checks++;
        if (cnt_o !== 4'd3) begin
            failures++; $display("FAIL t2_count got=%0d want=3", cnt_o);
        end
        checks++;
        if (addr_pulses - ap !== 1 || instr_pulses - ip !== 1) begin
            failures++;
            $display("FAIL t2_pulses got=%0d/%0d want=1/1", addr_pulses - ap, instr_pulses - ip);
        end
    endtask

    task automatic test_timeout();
        int n, ap;
        ap = addr_pulses;
        addr_d = 32'h0000_3000;
        addr_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_o && n < 10);
        n = 1;
        while (n < 40) begin
            @(negedge clk);
            if (req_o) n++;
            else break;
        end
        checks++;
        if (n !== 16) begin
            failures++; $display("FAIL t3_req_cycles got=%0d want=16", n);
        end
        checks++;
        if (timeout_o !== 1'b1 || req_o !== 1'b0) begin
            failures++; $display("FAIL t3_abort got=%b%b want=10", timeout_o, req_o);
        end
        checks++;
        if (addr_pulses !== ap || cnt_o !== 4'd3) begin
            failures++;
            $display("FAIL t3_no_clear got=%0d/%0d want=0/3", addr_pulses - ap, cnt_o);
        end
        xfer(1'b0, 32'h0000_3000, 0, "t3_retry");
        checks++;
        if (timeout_o !== 1'b1 || cnt_o !== 4'd4) begin
            failures++; $display("FAIL t3_sticky got=%b/%0d want=1/4", timeout_o, cnt_o);
        end
        tclr = 1'b1;
        @(negedge clk);
        tclr = 1'b0;
        checks++;
        if (timeout_o !== 1'b0) begin
            failures++; $display("FAIL t3_clear got=%b want=0", timeout_o);
        end
    endtask

    task automatic test_reset_in_clr();
        int n;
        model_en = 1'b0;
        addr_d = 32'h0000_4444;
        addr_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_o && n < 10);
        repeat (3) @(negedge clk);
        ack = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (rst_addr_o && n < 20);
        checks++;
        if (rst_addr_o !== 1'b0) begin
            failures++; $display("FAIL t4_clr_seen got=%b want=0", rst_addr_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rst_addr_o, rst_instr_o, req_o, busy_o} !== 4'b1100) begin
            failures++;
            $display("FAIL t4_async got=%b want=1100", {rst_addr_o, rst_instr_o, req_o, busy_o});
        end
        checks++;
        if (cnt_o !== '0) begin
            failures++; $display("FAIL t4_count got=%0d want=0", cnt_o);
        end
        @(negedge clk);
        ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_en = 1'b1;
        xfer(1'b0, 32'h0000_4444, 0, "t4_retry");
        checks++;
        if (cnt_o !== 4'd1) begin
            failures++; $display("FAIL t4_count_after got=%0d want=1", cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 15; i++) begin
            addr_d = 32'h0000_5000 + DW'(i);
            addr_valid = 1'b1;
            xfer(1'b0, 32'h0000_5000 + DW'(i), 0, "t5_wrap");
        end
        checks++;
        if (cnt_o !== 4'd0) begin
            failures++; $display("FAIL t5_wrap_count got=%0d want=0", cnt_o);
        end
    endtask

    task automatic test_ack_hold();
        int n, hi;
        addr_d = 32'h0000_6000;
        addr_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_o && n < 10);
        repeat (3) @(negedge clk);
        ack = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (req_o && n < 30);
        addr_d = 32'h0000_7000;
        addr_valid = 1'b1;
        hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (req_o) hi++;
        end
        checks++;
        if (hi !== 0 || busy_o !== 1'b1) begin
            failures++; $display("FAIL t5_hold got=%0d/%b want=0/1", hi, busy_o);
        end
        ack = 1'b0;
        xfer(1'b0, 32'h0000_7000, 0, "t5_after_hold");
        checks++;
        if (cnt_o !== 4'd2) begin
            failures++; $display("FAIL t5_hold_count got=%0d want=2", cnt_o);
        end
        checks++;
        if (both_low !== 0) begin
            failures++; $display("FAIL both_clears_low got=%0d want=0", both_low);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_single_addr();
        test_arbitration();
        test_timeout();
        test_reset_in_clr();
        test_back_to_back();
        test_ack_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
